bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per operand (range 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port inA, input, 4*DIGITS, packed BCD operand A; digit 0 in bits [3:0].
REQ-006 SHALL have port inB, input, 4*DIGITS, packed BCD operand B.
REQ-007 SHALL have port carryIn, input, 1, decimal carry into digit 0.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-010 SHALL have port sumBCD, output, 4*DIGITS, packed BCD sum.
REQ-011 SHALL have port acarreoBCD, output, 1, decimal carry out of the top digit.
REQ-012 SHALL have port sumVal, output, 1, high only if every operand digit of A and B is 0..9.

Function
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 In IDLE with start=1, SHALL capture inA, inB and carryIn into internal registers, clear the digit index to 0, clear the validity flag to 1, and go to ADD.
REQ-015 In ADD, SHALL add one digit pair per cycle, LSB digit first, using the registered decimal carry (carryIn for digit 0).
REQ-016 Each digit step SHALL form a binary sum; if the sum exceeds 9 or has a binary carry, SHALL add 6, keep the low 4 bits, and set the decimal carry to 1; otherwise the decimal carry is 0.
REQ-017 Each digit step SHALL clear the validity flag if either operand digit exceeds 9; the sum digit is still computed per REQ-016.
REQ-018 After the step for digit DIGITS-1, SHALL go to DONE, with sumBCD, acarreoBCD and sumVal updated at that same edge.
REQ-019 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed: done is high in cycle DIGITS+1 after the cycle in which start was sampled; start is accepted again in the cycle after done.
REQ-021 busy SHALL be 1 in ADD and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored outside IDLE; operand input changes during ADD SHALL have no effect.
REQ-023 sumBCD, acarreoBCD and sumVal SHALL hold their last values until the next completion or reset.

Reset
REQ-024 With reset=1 at a clock edge, SHALL go to IDLE and clear busy, done, sumBCD, acarreoBCD and sumVal to 0, clearing all internal registers as well.
REQ-025 Reset SHALL override start and any in-progress operation (abort, no done pulse).

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the BCD digit width constant (4), and the correction constant (6).
REQ-027 The per-digit add/correct logic SHALL be one combinational sub-module, bcd_digit_add (ports: two digits, carry in, sum digit, decimal carry out, digit-valid flag), instantiated once and time-shared.

Verification
REQ-028 inA=16'h1234, inB=16'h5678, carryIn=0, start pulse -> done in cycle 5; sumBCD=16'h6912, acarreoBCD=0, sumVal=1.
REQ-029 inA=16'h9999, inB=16'h0001, carryIn=0 -> sumBCD=16'h0000, acarreoBCD=1, sumVal=1.
REQ-030 inA=16'h0000, inB=16'h0000, carryIn=1 -> sumBCD=16'h0001, acarreoBCD=0; separately, inA=16'h12A4, inB=16'h0001 -> sumVal=0, done still pulses in cycle 5.
REQ-031 Second start pulse during ADD, with changed operands -> ignored; the result matches the first operands and exactly one done pulse occurs.
REQ-032 reset asserted in cycle 2 of ADD -> next cycle busy=0, done=0, sumBCD=0; no done pulse follows; a new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_serial_adder_pkg;

    localparam int unsigned DIG_W = 4;

    localparam logic [DIG_W-1:0] BCD_CORR = 4'd6;

    localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_adder_digit.sv
// One BCD digit step: binary add, decimal correction, operand validity.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [DIG_W-1:0] i_a,
    input  logic [DIG_W-1:0] i_b,
    input  logic             i_cin,
    output logic [DIG_W-1:0] o_sum_c,
    output logic             o_cout_c,
    output logic             o_valid_c
);

    logic [DIG_W:0] w_bin;

    // Binary sum and decimal correction; >9 also covers the binary-carry case
    always_comb begin
        w_bin     = (DIG_W+1)'(i_a) + (DIG_W+1)'(i_b) + (DIG_W+1)'(i_cin);
        o_cout_c  = (w_bin > (DIG_W+1)'(BCD_MAX));
        o_sum_c   = o_cout_c ? DIG_W'(w_bin[DIG_W-1:0] + BCD_CORR) : w_bin[DIG_W-1:0];
        o_valid_c = (i_a <= BCD_MAX) && (i_b <= BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit pair per cycle, LSB first.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     inA,
    input  logic [4*DIGITS-1:0]     inB,
    input  logic                    carryIn,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sumBCD,
    output logic                    acarreoBCD,
    output logic                    sumVal
);

    localparam int unsigned W     = DIG_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;

    logic [DIG_W-1:0]   w_sum_dig;
    logic               w_cout;
    logic               w_dig_valid;
    logic               w_last;
    logic [W-1:0]       w_sum_nxt;

    // Single time-shared digit adder, always fed from the low digit of the operand shifters
    bcd_digit_add u_digit (
        .i_a       (r_a[DIG_W-1:0]),
        .i_b       (r_b[DIG_W-1:0]),
        .i_cin     (r_carry),
        .o_sum_c   (w_sum_dig),
        .o_cout_c  (w_cout),
        .o_valid_c (w_dig_valid)
    );

    // Last-digit detect and sum shift-in from the top
    always_comb begin
        w_last    = (r_idx == IDX_W'(DIGITS - 1));
        w_sum_nxt = (r_sum >> DIG_W) | (W'(w_sum_dig) << (W - DIG_W));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sumBCD     <= '0;
            acarreoBCD <= 1'b0;
            sumVal     <= 1'b0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= inA;
                        r_b     <= inB;
                        r_carry <= carryIn;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_sum   <= '0;
                    end
                end
                S_ADD: begin
                    r_a     <= r_a >> DIG_W;
                    r_b     <= r_b >> DIG_W;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    r_valid <= r_valid & w_dig_valid;
                    r_sum   <= w_sum_nxt;
                    if (w_last) begin
                        sumBCD     <= w_sum_nxt;
                        acarreoBCD <= w_cout;
                        sumVal     <= r_valid & w_dig_valid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         carryIn;
    logic         busy;
    logic         done;
    logic [W-1:0] sumBCD;
    logic         acarreoBCD;
    logic         sumVal;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_val;
    } vec_t;

    vec_t vecs[8];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .inA        (inA),
        .inB        (inB),
        .carryIn    (carryIn),
        .busy       (busy),
        .done       (done),
        .sumBCD     (sumBCD),
        .acarreoBCD (acarreoBCD),
        .sumVal     (sumVal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns after the edge that samples it
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        inA     = a;
        inB     = b;
        carryIn = cin;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Count cycles until done; cycle 1 is the one after start was sampled
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int n_done;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        inA      = '0;
        inB      = '0;
        carryIn  = 1'b0;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b1};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b0};
        vecs[4] = '{16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b1};
        vecs[6] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h5554, 1'b1, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sumBCD), 32'd0);
        check("rst_carry", 32'(acarreoBCD), 32'd0);
        check("rst_val", 32'(sumVal), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_done(cyc);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'(DIGITS + 1));
            check($sformatf("v%0d_sum", i), 32'(sumBCD), 32'(vecs[i].exp_sum));
            check($sformatf("v%0d_carry", i), 32'(acarreoBCD), 32'(vecs[i].exp_c));
            check($sformatf("v%0d_val", i), 32'(sumVal), 32'(vecs[i].exp_val));
            tick();
            check($sformatf("v%0d_done_clr", i), 32'(done), 32'd0);
            check($sformatf("v%0d_busy_clr", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(sumBCD), 32'(vecs[i].exp_sum));
        end

        // Second start during ADD with changed operands is ignored
        launch(16'h1234, 16'h5678, 1'b0);
        tick();
        inA   = 16'h9999;
        inB   = 16'h9999;
        start = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) begin
                n_done++;
                check("ign_sum", 32'(sumBCD), 32'h6912);
                check("ign_carry", 32'(acarreoBCD), 32'd0);
            end
            tick();
        end
        check("ign_done_count", 32'(n_done), 32'd1);

        // Reset mid-operation aborts with no done pulse
        launch(16'h0000, 16'h0000, 1'b0);
        launch(16'h4321, 16'h1111, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sumBCD), 32'd0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        launch(16'h0505, 16'h0505, 1'b0);
        wait_done(cyc);
        check("post_latency", 32'(cyc), 32'(DIGITS + 1));
        check("post_sum", 32'(sumBCD), 32'h1010);
        check("post_val", 32'(sumVal), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
